// File: rtl/seven_seg_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_mux_pkg
// Brief   : Shared glyph constants (active-low segment form) for the hex display.
// Revision: 1.0
// ============================================================================
package seven_seg_mux_pkg;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic       DP_OFF  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seven_seg_mux_hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module  : hex_to_7seg
// Brief   : Combinational 4-bit nibble to active-low 7-segment glyph decoder.
// Revision: 1.0
// ============================================================================
module hex_to_7seg
    import seven_seg_mux_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_OFF;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_mux.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_mux
// Brief   : Time-multiplexed hex display driver with per-frame value snapshot
//           and optional leading-zero blanking.
// Revision: 1.0
// ============================================================================
module seven_seg_mux
    import seven_seg_mux_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int C_PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int C_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [C_PRE_W-1:0] C_TC   = C_PRE_W'(REFRESH_DIV - 1);
    localparam logic [C_IDX_W-1:0] C_LAST = C_IDX_W'(DIGITS - 1);

    // XOR masks that turn the internal active-low form into pin polarity.
    localparam logic [6:0]        C_SEG_POL = (SEG_ACT_LOW != 0) ? 7'h00 : 7'h7F;
    localparam logic              C_DP_POL  = (SEG_ACT_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [DIGITS-1:0] C_AN_POL  = (AN_ACT_LOW != 0) ? '0 : '1;

    logic [C_PRE_W-1:0]  r_pre;
    logic [C_IDX_W-1:0]  r_idx;
    logic [4*DIGITS-1:0] r_shadow;
    logic                r_first;
    logic                r_frame_tick;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;

    logic                w_tc;
    logic                w_load;
    logic [C_PRE_W-1:0]  w_pre_nxt;
    logic [C_IDX_W-1:0]  w_idx_nxt;
    logic [4*DIGITS-1:0] w_shadow_nxt;
    logic [3:0]          w_nibble;
    logic                w_dp_sel;
    logic                w_tail_zero;
    logic                w_blank;
    logic [DIGITS-1:0]   w_onehot;
    logic [6:0]          w_glyph;

    always_comb begin
        w_tc         = (r_pre == C_TC);
        w_pre_nxt    = w_tc ? '0 : r_pre + 1'b1;
        w_idx_nxt    = r_idx;
        if (w_tc) begin
            w_idx_nxt = (r_idx == C_LAST) ? '0 : r_idx + 1'b1;
        end
        // r_first forces a reload on the first edge after reset release.
        w_load       = r_first | (w_tc & (r_idx == C_LAST));
        w_shadow_nxt = w_load ? value : r_shadow;

        w_nibble    = '0;
        w_dp_sel    = 1'b0;
        w_tail_zero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == C_IDX_W'(i)) begin
                w_nibble    = w_shadow_nxt[i*4 +: 4];
                w_dp_sel    = dp_mask[i];
                w_tail_zero = ((w_shadow_nxt >> (4 * i)) == '0);
            end
        end

        w_blank  = blank_lz & (w_idx_nxt != '0) & w_tail_zero;
        w_onehot = w_blank ? '0 : (DIGITS'(1) << w_idx_nxt);
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (w_nibble),
        .glyph  (w_glyph)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_first      <= 1'b1;
            r_frame_tick <= 1'b0;
            r_seg        <= SEG_OFF ^ C_SEG_POL;
            r_dp         <= DP_OFF ^ C_DP_POL;
            r_an         <= '1 ^ C_AN_POL;
        end else begin
            r_pre        <= w_pre_nxt;
            r_idx        <= w_idx_nxt;
            r_shadow     <= w_shadow_nxt;
            r_first      <= 1'b0;
            r_frame_tick <= w_load;
            r_seg        <= (w_blank ? SEG_OFF : w_glyph) ^ C_SEG_POL;
            r_dp         <= ((w_dp_sel & ~w_blank) ? 1'b0 : DP_OFF) ^ C_DP_POL;
            r_an         <= ~w_onehot ^ C_AN_POL;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_mux
// Brief   : Self-checking bench for seven_seg_mux (DIGITS=4, REFRESH_DIV=4).
// Revision: 1.0
// ============================================================================
module tb_seven_seg_mux;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = 16'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_mask = 4'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seven_seg_mux #(
        .DIGITS      (4),
        .REFRESH_DIV (4),
        .SEG_ACT_LOW (1),
        .AN_ACT_LOW  (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: edge n after release shows digit (n/4)%4; reload at n==1 and n%16==0.
    logic [6:0]  glyph_tbl [16];
    int          m_n = 0;
    int          m_d = 0;
    logic [15:0] m_shadow = 16'h0;
    logic        m_blank;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic        exp_tick = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_n      = 0;
            m_shadow = 16'h0;
            exp_an   = 4'hF;
            exp_seg  = 7'h7F;
            exp_dp   = 1'b1;
            exp_tick = 1'b0;
        end else begin
            m_n = m_n + 1;
            if (m_n == 1 || m_n % 16 == 0) begin
                m_shadow = value;
                exp_tick = 1'b1;
            end else begin
                exp_tick = 1'b0;
            end
            m_d     = (m_n / 4) % 4;
            m_blank = blank_lz && m_d > 0 && ((m_shadow >> (4 * m_d)) == 16'h0);
            exp_an  = m_blank ? 4'hF : ~(4'b0001 << m_d);
            exp_seg = m_blank ? 7'h7F : glyph_tbl[m_shadow[4*m_d +: 4]];
            exp_dp  = !(dp_mask[m_d] && !m_blank);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_model();
        chk("mdl_an", 32'(an), 32'(exp_an));
        chk("mdl_seg", 32'(seg), 32'(exp_seg));
        chk("mdl_dp", 32'(dp), 32'(exp_dp));
        chk("mdl_tick", 32'(frame_tick), 32'(exp_tick));
    endtask

    typedef struct {
        logic [15:0]     value;
        logic            blank;
        logic [3:0]      dpm;
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        glyph_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        vecs[0] = '{16'h1234, 1'b0, 4'b0000,
                    {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
        vecs[1] = '{16'h0005, 1'b1, 4'b0000,
                    {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {7'h7F, 7'h7F, 7'h7F, 7'b0010010}, 4'b1111};
        vecs[2] = '{16'h0000, 1'b1, 4'b0100,
                    {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
        vecs[3] = '{16'hABCD, 1'b0, 4'b0100,
                    {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'b1011};
        vecs[4] = '{16'h0F00, 1'b1, 4'b1111,
                    {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h7F, 7'b0001110, 7'b1000000, 7'b1000000}, 4'b1000};

        // Reset state
        tick(2);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_tick", 32'(frame_tick), 32'h0);

        // First frame after release and digit advance
        value = 16'h1234;
        reset_n = 1'b1;
        tick(1);
        chk("first_tick", 32'(frame_tick), 32'h1);
        chk("first_an", 32'(an), 32'hE);
        chk("first_seg", 32'(seg), 32'b0011001);
        tick(3);
        chk("d1_an", 32'(an), 32'hD);
        chk("d1_seg", 32'(seg), 32'b0110000);
        chk("d1_tick", 32'(frame_tick), 32'h0);

        // Mid-frame value change is invisible until the next reload (edge 16)
        tick(2);
        value = 16'hABCD;
        tick(8);
        chk("old_an", 32'(an), 32'h7);
        chk("old_seg", 32'(seg), 32'b1111001);
        tick(2);
        chk("reload_tick", 32'(frame_tick), 32'h1);
        chk("reload_an", 32'(an), 32'hE);
        chk("reload_seg", 32'(seg), 32'b0100001);
        tick(4);
        chk("new_d1_seg", 32'(seg), 32'b1000110);

        // Asynchronous reset between edges
        #2 reset_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_dp", 32'(dp), 32'h1);
        chk("async_tick", 32'(frame_tick), 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        chk("restart_an", 32'(an), 32'hE);
        chk("restart_seg", 32'(seg), 32'b0100001);
        chk("restart_tick", 32'(frame_tick), 32'h1);

        // Frame tick cadence
        for (int k = 2; k <= 33; k++) begin
            tick(1);
            chk("cadence_tick", 32'(frame_tick), 32'((k % 16) == 0));
        end

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            reset_n  = 1'b0;
            value    = vecs[v].value;
            blank_lz = vecs[v].blank;
            dp_mask  = vecs[v].dpm;
            tick(1);
            reset_n = 1'b1;
            tick(2);
            for (int d = 0; d < 4; d++) begin
                chk("tbl_an", 32'(an), 32'(vecs[v].an[d]));
                chk("tbl_seg", 32'(seg), 32'(vecs[v].seg[d]));
                chk("tbl_dp", 32'(dp), 32'(vecs[v].dp[d]));
                tick(4);
            end
        end

        // Randomized stimulus against the reference model
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            tick(1);
            chk_model();
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if ($urandom_range(0, 249) == 0) begin
                #2 reset_n = 1'b0;
                #1 chk_model();
            end
            if ($urandom_range(0, 6) == 0) begin
                case ($urandom_range(0, 3))
                    0: value = 16'($urandom);
                    1: value = 16'($urandom_range(0, 255));
                    2: value = 16'h0;
                    default: value = {12'h0, 4'($urandom)};
                endcase
            end
            if ($urandom_range(0, 9) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 9) == 0) dp_mask = 4'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
